mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the core's instruction-fetch and load/store paths onto one registered memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed D-over-I priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | no access in flight; arbitrate masked requests
    // BUSY_I | fetch access on the memory port, waiting for m_ready
    // BUSY_D | load/store access on the memory port, waiting for m_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t state;
    logic   last_grant_d;
    logic   i_req_m;
    logic   d_req_m;
    logic   tie_to_i;
    logic   grant_i;
    logic   grant_d;

    // A requester is ignored in its own ack cycle so a still-high req is not served twice.
    always_comb begin
        i_req_m  = i_req & ~i_ack;
        d_req_m  = d_req & ~d_ack;
        tie_to_i = RR_EN & last_grant_d;
        grant_i  = i_req_m & (~d_req_m | tie_to_i);
        grant_d  = d_req_m & ~(i_req_m & tie_to_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            busy         <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        busy    <= 1'b1;
                        state   <= BUSY_D;
                    end else if (grant_i) begin
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                        busy   <= 1'b1;
                        state  <= BUSY_I;
                    end else begin
                        m_req <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (m_ready) begin
                        m_req        <= 1'b0;
                        i_ack        <= 1'b1;
                        i_rdata      <= m_rdata;
                        last_grant_d <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        d_ack <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        last_grant_d <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    m_req <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
